alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Sequential ALU with valid/ready handshakes. Single-cycle logic,
//             shift and compare ops, iterative shift-add multiply, and an
//             optional restoring divider enabled by macro ALU_SEQ_DIV_EN.
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         opcode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] res,
    output logic               carry,
    output logic               zero,
    output logic               err
);

    localparam int c_RW    = 2 * WIDTH;
    localparam int c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [3:0] c_OP_ADD  = 4'h0;
    localparam logic [3:0] c_OP_SUB  = 4'h1;
    localparam logic [3:0] c_OP_MULT = 4'h2;
    localparam logic [3:0] c_OP_DIV  = 4'h3;
    localparam logic [3:0] c_OP_AND  = 4'h4;
    localparam logic [3:0] c_OP_OR   = 4'h5;
    localparam logic [3:0] c_OP_NAND = 4'h6;
    localparam logic [3:0] c_OP_NOR  = 4'h7;
    localparam logic [3:0] c_OP_XOR  = 4'h8;
    localparam logic [3:0] c_OP_SHR  = 4'h9;
    localparam logic [3:0] c_OP_SHL  = 4'hA;
    localparam logic [3:0] c_OP_COMP = 4'hB;

    typedef enum logic [1:0] {
        c_ST_IDLE = 2'd0,
        c_ST_EXEC = 2'd1,
        c_ST_DONE = 2'd2
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [3:0]           r_op_q, w_op_d;
    logic [WIDTH-1:0]     r_a_q, w_a_d;
    logic [WIDTH-1:0]     r_b_q, w_b_d;
    logic [c_CNT_W-1:0]   r_cnt_q, w_cnt_d;
    logic [c_RW-1:0]      r_acc_q, w_acc_d;
    logic [c_RW-1:0]      r_res_q, w_res_d;
    logic                 r_carry_q, w_carry_d;
    logic                 r_zero_q, w_zero_d;
    logic                 r_err_q, w_err_d;
    logic                 r_in_ready_q, w_in_ready_d;
    logic                 r_out_valid_q, w_out_valid_d;

    logic [WIDTH-1:0]     w_lo;
    logic                 w_fill;
    logic                 w_multi;
    logic [c_RW-1:0]      w_alu_res;
    logic                 w_alu_carry;
    logic                 w_alu_err;
    logic [WIDTH:0]       w_madd;
    logic [c_RW-1:0]      w_mul_next;
    logic [c_RW-1:0]      w_step;

    // Shift-add multiply: acc = {partial product, remaining multiplier bits}
    assign w_madd     = {1'b0, r_acc_q[c_RW-1:WIDTH]} + (r_acc_q[0] ? {1'b0, r_a_q} : '0);
    assign w_mul_next = {w_madd, r_acc_q[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0]       w_dcand;
    logic                 w_dge;
    logic [WIDTH-1:0]     w_ddiff;
    logic [c_RW-1:0]      w_div_next;

    // Restoring divide: acc = {partial remainder, dividend shifting into quotient}
    assign w_dcand    = {r_acc_q[c_RW-1:WIDTH], r_acc_q[WIDTH-1]};
    assign w_dge      = (w_dcand >= {1'b0, r_b_q});
    assign w_ddiff    = w_dcand[WIDTH-1:0] - r_b_q;
    assign w_div_next = {(w_dge ? w_ddiff : w_dcand[WIDTH-1:0]), r_acc_q[WIDTH-2:0], w_dge};
    assign w_step     = (r_op_q == c_OP_DIV) ? w_div_next : w_mul_next;
`else
    assign w_step     = w_mul_next;
`endif

    always_comb begin
        w_lo        = '0;
        w_fill      = 1'b0;
        w_multi     = 1'b0;
        w_alu_carry = 1'b0;
        w_alu_err   = 1'b0;
        case (r_op_q)
            c_OP_ADD:  {w_alu_carry, w_lo} = {1'b0, r_a_q} + {1'b0, r_b_q};
            c_OP_SUB: begin
                w_lo        = r_a_q - r_b_q;
                w_alu_carry = (r_a_q < r_b_q);
            end
            c_OP_MULT: w_multi = 1'b1;
`ifdef ALU_SEQ_DIV_EN
            c_OP_DIV: begin
                if (r_b_q == '0) w_alu_err = 1'b1;
                else             w_multi   = 1'b1;
            end
`else
            c_OP_DIV:  w_alu_err = 1'b1;
`endif
            c_OP_AND:  w_lo = r_a_q & r_b_q;
            c_OP_OR:   w_lo = r_a_q | r_b_q;
            c_OP_NAND: w_lo = ~(r_a_q & r_b_q);
            c_OP_NOR:  w_lo = ~(r_a_q | r_b_q);
            c_OP_XOR:  w_lo = r_a_q ^ r_b_q;
            c_OP_SHR: begin
                w_lo        = r_a_q >> 1;
                w_alu_carry = r_a_q[0];
            end
            c_OP_SHL: begin
                w_lo        = r_a_q << 1;
                w_alu_carry = r_a_q[WIDTH-1];
            end
            c_OP_COMP: w_fill = (r_a_q > r_b_q);
            default:   w_alu_err = 1'b1;
        endcase
        w_alu_res = w_fill ? '1 : {{WIDTH{1'b0}}, w_lo};
    end

    always_comb begin
        w_state_d = r_state_q;
        w_op_d    = r_op_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_cnt_d   = r_cnt_q;
        w_acc_d   = r_acc_q;
        w_res_d   = r_res_q;
        w_carry_d = r_carry_q;
        w_zero_d  = r_zero_q;
        w_err_d   = r_err_q;
        case (r_state_q)
            c_ST_IDLE: begin
                if (in_valid) begin
                    w_op_d    = opcode;
                    w_a_d     = a;
                    w_b_d     = b;
                    w_cnt_d   = '0;
                    w_acc_d   = {{WIDTH{1'b0}}, b};
`ifdef ALU_SEQ_DIV_EN
                    if (opcode == c_OP_DIV) w_acc_d = {{WIDTH{1'b0}}, a};
`endif
                    w_state_d = c_ST_EXEC;
                end
            end
            c_ST_EXEC: begin
                if (w_multi) begin
                    w_acc_d = w_step;
                    w_cnt_d = r_cnt_q + c_CNT_W'(1);
                end
                if (!w_multi || (r_cnt_q == c_CNT_LAST)) begin
                    w_res_d   = w_multi ? w_step : w_alu_res;
                    w_carry_d = w_alu_carry;
                    w_err_d   = w_alu_err;
                    w_zero_d  = (w_res_d == '0);
                    w_state_d = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (out_ready) w_state_d = c_ST_IDLE;
            end
            default: w_state_d = c_ST_IDLE;
        endcase
        w_in_ready_d  = (w_state_d == c_ST_IDLE);
        w_out_valid_d = (w_state_d == c_ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= c_ST_IDLE;
            r_op_q        <= '0;
            r_a_q         <= '0;
            r_b_q         <= '0;
            r_cnt_q       <= '0;
            r_acc_q       <= '0;
            r_res_q       <= '0;
            r_carry_q     <= 1'b0;
            r_zero_q      <= 1'b0;
            r_err_q       <= 1'b0;
            r_in_ready_q  <= 1'b1;
            r_out_valid_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_op_q        <= w_op_d;
            r_a_q         <= w_a_d;
            r_b_q         <= w_b_d;
            r_cnt_q       <= w_cnt_d;
            r_acc_q       <= w_acc_d;
            r_res_q       <= w_res_d;
            r_carry_q     <= w_carry_d;
            r_zero_q      <= w_zero_d;
            r_err_q       <= w_err_d;
            r_in_ready_q  <= w_in_ready_d;
            r_out_valid_q <= w_out_valid_d;
        end
    end

    assign in_ready  = r_in_ready_q;
    assign out_valid = r_out_valid_q;
    assign res       = r_res_q;
    assign carry     = r_carry_q;
    assign zero      = r_zero_q;
    assign err       = r_err_q;

endmodule
`default_nettype wire
